// File: rtl/rotate_shift_scheduler.sv
// Two-requester arbiter and sequencer driving one shared rotate-right shifter.
// Define ROTATE_SCHED_ROUNDROBIN_EN for round-robin grants; otherwise requester 0 has fixed priority.
module rotate_shift_scheduler #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  input  logic [1:0][WIDTH-1:0]  req_data,
  input  logic [1:0][AMT_W-1:0]  req_amt,
  output logic [1:0]             req_ready,
  output logic                   rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_id,
  input  logic                   rsp_ready,
  output logic                   busy,
  output logic                   sh_load,
  output logic                   sh_shift,
  output logic [WIDTH-1:0]       sh_data_in,
  input  logic [WIDTH-1:0]       sh_data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [AMT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               id_q, id_d;
  logic               busy_q, busy_d;
  logic               sh_load_q, sh_load_d;
  logic               sh_shift_q, sh_shift_d;
  logic [WIDTH-1:0]   sh_data_in_q, sh_data_in_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic               grant_s;
  logic [1:0]         req_ready_s;
  logic               hs_s;
`ifdef ROTATE_SCHED_ROUNDROBIN_EN
  logic               ptr_q, ptr_d;
`endif

  // Arbiter: pick a winner and raise its ready only while idle and out of reset
  always_comb begin
    grant_s     = 1'b0;
    req_ready_s = 2'b00;
`ifdef ROTATE_SCHED_ROUNDROBIN_EN
    if (req_valid[ptr_q]) begin
      grant_s = ptr_q;
    end else begin
      grant_s = ~ptr_q;
    end
`else
    if (req_valid[0]) begin
      grant_s = 1'b0;
    end else begin
      grant_s = 1'b1;
    end
`endif
    if ((state_q == IDLE) && !reset && (req_valid != 2'b00)) begin
      req_ready_s[grant_s] = 1'b1;
    end else begin
      req_ready_s = 2'b00;
    end
  end

  assign req_ready = req_ready_s;
  assign hs_s      = |(req_valid & req_ready_s);

  // Next-state, capture and counter logic; output flops are derived from the next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    id_d    = id_q;
`ifdef ROTATE_SCHED_ROUNDROBIN_EN
    if (hs_s) begin
      ptr_d = ~grant_s;
    end else begin
      ptr_d = ptr_q;
    end
`endif
    case (state_q)
      IDLE: begin
        if (hs_s) begin
          data_d  = req_data[grant_s];
          cnt_d   = req_amt[grant_s];
          id_d    = grant_s;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (cnt_q == {AMT_W{1'b0}}) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Leaving on a count of one gives exactly 'amount' shift cycles
        if (cnt_q == AMT_W'(1)) begin
          cnt_d   = {AMT_W{1'b0}};
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q - AMT_W'(1);
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {AMT_W{1'b0}};
      end
    endcase

    busy_d      = (state_d != IDLE);
    sh_load_d   = (state_d == LOAD);
    sh_shift_d  = (state_d == SHIFT);
    rsp_valid_d = (state_d == DONE);
    if (state_d == LOAD) begin
      sh_data_in_d = data_d;
    end else begin
      sh_data_in_d = {WIDTH{1'b0}};
    end
    if (state_d == DONE) begin
      rsp_id_d = id_d;
    end else begin
      rsp_id_d = 1'b0;
    end
  end

  // State, captured request and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= {AMT_W{1'b0}};
      data_q       <= {WIDTH{1'b0}};
      id_q         <= 1'b0;
      busy_q       <= 1'b0;
      sh_load_q    <= 1'b0;
      sh_shift_q   <= 1'b0;
      sh_data_in_q <= {WIDTH{1'b0}};
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
`ifdef ROTATE_SCHED_ROUNDROBIN_EN
      ptr_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      id_q         <= id_d;
      busy_q       <= busy_d;
      sh_load_q    <= sh_load_d;
      sh_shift_q   <= sh_shift_d;
      sh_data_in_q <= sh_data_in_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
`ifdef ROTATE_SCHED_ROUNDROBIN_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

  // The shifter holds in DONE, so its output is passed straight through while valid
  assign rsp_data   = rsp_valid_q ? sh_data_out : {WIDTH{1'b0}};
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign busy       = busy_q;
  assign sh_load    = sh_load_q;
  assign sh_shift   = sh_shift_q;
  assign sh_data_in = sh_data_in_q;

endmodule

// File: tb/tb_rotate_shift_scheduler.sv
// Directed bench for rotate_shift_scheduler with a behavioural 8-bit rotate-right shifter.
// Contention expectations follow ROTATE_SCHED_ROUNDROBIN_EN when defined.
module tb_rotate_shift_scheduler;

  logic             clk;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0][7:0]  req_data;
  logic [1:0][2:0]  req_amt;
  logic [1:0]       req_ready;
  logic             rsp_valid;
  logic [7:0]       rsp_data;
  logic             rsp_id;
  logic             rsp_ready;
  logic             busy;
  logic             sh_load;
  logic             sh_shift;
  logic [7:0]       sh_data_in;
  logic [7:0]       sh_data_out;

  int n_checks = 0;
  int n_errors = 0;

  rotate_shift_scheduler dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_amt(req_amt), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
    .busy(busy), .sh_load(sh_load), .sh_shift(sh_shift),
    .sh_data_in(sh_data_in), .sh_data_out(sh_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference shifter: load wins, otherwise rotate right by one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sh_data_out <= 8'h00;
    else if (sh_load) sh_data_out <= sh_data_in;
    else if (sh_shift) sh_data_out <= {sh_data_out[0], sh_data_out[7:1]};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".req_ready"}, {30'd0, req_ready}, 32'd0);
    check_eq({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check_eq({tag, ".rsp_data"}, {24'd0, rsp_data}, 32'd0);
    check_eq({tag, ".rsp_id"}, {31'd0, rsp_id}, 32'd0);
    check_eq({tag, ".busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, ".sh_load"}, {31'd0, sh_load}, 32'd0);
    check_eq({tag, ".sh_shift"}, {31'd0, sh_shift}, 32'd0);
    check_eq({tag, ".sh_data_in"}, {24'd0, sh_data_in}, 32'd0);
  endtask

  // One request from start to first response cycle; leaves the DUT in its first DONE cycle
  task automatic do_req(input string tag, input int id, input logic [7:0] data, input logic [2:0] amt,
                        input logic [7:0] exp_data, input logic rdy);
    int waits;
    int cyc;
    int loads;
    int shifts;
    int first;
    @(negedge clk);
    req_valid[id] = 1'b1;
    req_data[id]  = data;
    req_amt[id]   = amt;
    rsp_ready     = rdy;
    waits = 0;
    #1;
    while (!req_ready[id] && waits < 20) begin
      @(negedge clk);
      #1;
      waits++;
    end
    check_eq({tag, ".grant"}, {31'd0, req_ready[id]}, 32'd1);
    @(posedge clk);
    cyc = 0; loads = 0; shifts = 0; first = -1;
    while (first < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) req_valid[id] = 1'b0;
      #1;
      loads  += int'(sh_load);
      shifts += int'(sh_shift);
      if (sh_load) check_eq({tag, ".sh_data_in"}, {24'd0, sh_data_in}, {24'd0, data});
      if (sh_load && sh_shift) check_eq({tag, ".excl"}, 32'd1, 32'd0);
      if (rsp_valid) first = cyc;
    end
    check_eq({tag, ".latency"}, first, int'(amt) + 2);
    check_eq({tag, ".loads"}, loads, 1);
    check_eq({tag, ".shifts"}, shifts, int'(amt));
    check_eq({tag, ".rsp_data"}, {24'd0, rsp_data}, {24'd0, exp_data});
    check_eq({tag, ".rsp_id"}, {31'd0, rsp_id}, id);
  endtask

  initial begin
    logic [3:0] exp_ids;
    logic [3:0] got_ids;
    int n_rsp;
    int bad_ready;
    int cyc;

    reset     = 1'b1;
    req_valid = 2'b11;
    req_data  = '0;
    req_amt   = '0;
    rsp_ready = 1'b0;
    #7;
    check_all_zero("reset");
    req_valid = 2'b00;
    #3;
    reset = 1'b0;

    do_req("load_only", 0, 8'hB4, 3'd0, 8'hB4, 1'b1);
    do_req("shift1", 1, 8'b10101010, 3'd1, 8'b01010101, 1'b1);
    do_req("amt7", 0, 8'h01, 3'd7, 8'h02, 1'b1);

    // Backpressure: response must hold while rsp_ready is low and a new request waits
    do_req("bp", 1, 8'hC3, 3'd2, 8'hF0, 1'b0);
    req_valid[0] = 1'b1;
    req_data[0]  = 8'h33;
    req_amt[0]   = 3'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check_eq("bp.rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("bp.rsp_data", {24'd0, rsp_data}, 32'hF0);
      check_eq("bp.rsp_id", {31'd0, rsp_id}, 32'd1);
      check_eq("bp.req_ready", {30'd0, req_ready}, 32'd0);
      check_eq("bp.sh_shift", {31'd0, sh_shift}, 32'd0);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check_eq("bp.release_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("bp.release_busy", {31'd0, busy}, 32'd0);

    // Contention: both requesters valid continuously
`ifdef ROTATE_SCHED_ROUNDROBIN_EN
    exp_ids = 4'b1010;
`else
    exp_ids = 4'b0000;
`endif
    got_ids = 4'b0000;
    @(negedge clk);
    req_data[0] = 8'h0F; req_amt[0] = 3'd2;
    req_data[1] = 8'hF0; req_amt[1] = 3'd2;
    req_valid   = 2'b11;
    rsp_ready   = 1'b1;
    n_rsp = 0; bad_ready = 0; cyc = 0;
    #1;
    while (n_rsp < 4 && cyc < 60) begin
      if (req_ready == 2'b11) bad_ready++;
      if (rsp_valid) begin
        got_ids[n_rsp] = rsp_id;
        check_eq("cont.rsp_data", {24'd0, rsp_data}, rsp_id ? 32'h3C : 32'hC3);
        n_rsp++;
      end
      if (n_rsp < 4) begin
        @(negedge clk);
        #1;
        cyc++;
      end
    end
    req_valid = 2'b00;
    check_eq("cont.count", n_rsp, 4);
    check_eq("cont.ids", {28'd0, got_ids}, {28'd0, exp_ids});
    check_eq("cont.ready_onehot", bad_ready, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("cont.idle", {31'd0, busy}, 32'd0);

    // Reset during the third SHIFT cycle of an amt-5 request
    @(negedge clk);
    req_valid[0] = 1'b1; req_data[0] = 8'h5A; req_amt[0] = 3'd5;
    rsp_ready = 1'b1;
    #1;
    check_eq("rst.grant", {31'd0, req_ready[0]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("rst.in_shift", {31'd0, sh_shift}, 32'd1);
    reset = 1'b1;
    #1;
    check_all_zero("rst.mid");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check_eq("rst.no_rsp", {31'd0, rsp_valid}, 32'd0);
      check_eq("rst.no_busy", {31'd0, busy}, 32'd0);
    end
    do_req("after_rst", 0, 8'h80, 3'd3, 8'h10, 1'b1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
